// File: rtl/nios2_debug_slave_pkg.sv
// Shared constants, entry layout and field-position helpers for the Nios II debug slave.
package nios2_debug_slave_pkg;

    localparam int unsigned IR_OCIMEM    = 0;
    localparam int unsigned IR_TRACE     = 1;
    localparam int unsigned IR_BREAK     = 2;
    localparam int unsigned IR_TRACECTRL = 3;

    localparam int unsigned DEF_IR_WIDTH = 2;
    localparam int unsigned DEF_DR_WIDTH = 38;
    localparam int unsigned DEF_NUM_CH   = 4;

    // Queue entry for the default configuration; parametrised instances use the same field order.
    typedef struct packed {
        logic [DEF_IR_WIDTH-1:0] ir;
        logic                    action;
        logic [DEF_NUM_CH-1:0]   ch;
        logic                    badch;
        logic [DEF_DR_WIDTH-1:0] data;
    } dbg_cmd_t;

    function automatic int unsigned ch_bits(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int unsigned action_pos(input int unsigned dr_w);
        return dr_w - 1;
    endfunction

    // Channel field sits directly below the action bit.
    function automatic int unsigned ch_lsb(input int unsigned dr_w, input int unsigned chb);
        return dr_w - 1 - chb;
    endfunction

endpackage

// File: rtl/nios2_debug_sync_edge.sv
// Multi-flop synchroniser followed by a rising-edge detector; resets to all ones
// so a level held high through reset never reports an edge.
module nios2_debug_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise_c
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_c = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/nios2_debug_slave_cmd_queue.sv
// System-clock command front end: synchronises JTAG update strobes, decodes
// commands and queues them for the on-chip-debug logic.
module nios2_debug_slave_cmd_queue
    import nios2_debug_slave_pkg::*;
#(
    parameter int unsigned IR_WIDTH    = 2,
    parameter int unsigned DR_WIDTH    = 38,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     vs_uir,
    input  logic                     vs_udr,
    input  logic [IR_WIDTH-1:0]      ir_in,
    input  logic [DR_WIDTH-1:0]      sr,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [IR_WIDTH-1:0]      cmd_ir,
    output logic                     cmd_action,
    output logic [NUM_CH-1:0]        cmd_ch,
    output logic                     cmd_badch,
    output logic [DR_WIDTH-1:0]      cmd_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    input  logic                     overflow_clr
);

    localparam int unsigned CH_BITS = ch_bits(NUM_CH);
    localparam int unsigned CH_FULL = 1 << CH_BITS;
    localparam int unsigned ACT_POS = action_pos(DR_WIDTH);
    localparam int unsigned CH_LSB  = ch_lsb(DR_WIDTH, CH_BITS);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned LVL_W   = PTR_W + 1;

    typedef struct packed {
        logic [IR_WIDTH-1:0] ir;
        logic                action;
        logic [NUM_CH-1:0]   ch;
        logic                badch;
        logic [DR_WIDTH-1:0] data;
    } entry_t;

    logic uir_rise_c, udr_rise_c;

    nios2_debug_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_uir (
        .clk      (clk),
        .reset    (reset),
        .async_in (vs_uir),
        .rise_c   (uir_rise_c)
    );

    nios2_debug_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_udr (
        .clk      (clk),
        .reset    (reset),
        .async_in (vs_udr),
        .rise_c   (udr_rise_c)
    );

    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                overflow_q, overflow_d;
    entry_t              mem_q [DEPTH];
    entry_t              mem_d [DEPTH];

    logic [CH_BITS-1:0]  ch_field;
    logic [CH_FULL-1:0]  ch_full;
    entry_t              new_entry;
    entry_t              head;
    logic                not_empty, full, push, pop, accept, drop;

    // Decode fields at push time; a channel at or above NUM_CH falls off the one-hot vector.
    always_comb begin
        ch_field         = sr[CH_LSB +: CH_BITS];
        ch_full          = CH_FULL'(1) << ch_field;
        new_entry.ir     = ir_q;
        new_entry.action = sr[ACT_POS];
        new_entry.ch     = NUM_CH'(ch_full);
        new_entry.badch  = ~|NUM_CH'(ch_full);
        new_entry.data   = sr;
    end

    always_comb begin
        not_empty = (level_q != '0);
        full      = (level_q == LVL_W'(DEPTH));
        push      = udr_rise_c;
        pop       = not_empty & cmd_ready;
        accept    = push & (~full | pop);
        drop      = push & full & ~pop;

        ir_d       = uir_rise_c ? ir_in : ir_q;
        wr_ptr_d   = accept ? PTR_W'(wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d   = pop ? PTR_W'(rd_ptr_q + 1'b1) : rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        mem_d      = mem_q;

        if (accept && !pop) begin
            level_d = LVL_W'(level_q + 1'b1);
        end else if (!accept && pop) begin
            level_d = LVL_W'(level_q - 1'b1);
        end

        if (accept) begin
            mem_d[wr_ptr_q] = new_entry;
        end

        // A dropped push in the same cycle as a clear leaves the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: empty-gating hides stale entries.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        head       = not_empty ? mem_q[rd_ptr_q] : '0;
        cmd_valid  = not_empty;
        cmd_ir     = head.ir;
        cmd_action = head.action;
        cmd_ch     = head.ch;
        cmd_badch  = head.badch;
        cmd_data   = head.data;
        fifo_level = level_q;
        overflow   = overflow_q;
    end

endmodule
